stopwatch_ctrl: RTL and testbench

//  Control FSM for the stopwatch: turns two button levels (START/STOP, LAP/RESET) into sequencing

---
 rtl/stopwatch_pkg.sv | 13 +
 rtl/btn_edge.sv | 26 ++
 rtl/stopwatch_ctrl.sv | 126 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding for the stopwatch control FSM
package stopwatch_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - two-flop synchroniser plus registered rising-edge pulse
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic ev
);

  logic sync1, sync2, sync3;

  // ev rises 3 clk after the raw level: two sync stages plus the registered edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      ev    <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      sync3 <= sync2;
      ev    <= sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch run/pause/lap/clear FSM; optional lap display hold via LAP_HOLD_EN
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int HOLD_TICKS = 20,
  parameter int LAP_CNT_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_ss,
  input  logic                 btn_lr,
  input  logic                 tick_10hz,
  input  logic                 time_max,
  output logic                 count_en,
  output logic                 count_clr,
  output logic                 lap_strobe,
  output logic                 lap_clr,
  output logic                 disp_freeze,
  output logic [LAP_CNT_W-1:0] lap_count,
  output logic [STATE_W-1:0]   state_o
);

  state_t state, state_nxt;
  logic   ev_ss, ev_lr;
  logic   lap_req, clr_req;

  btn_edge u_ss (.clk(clk), .rst(rst), .btn(btn_ss), .ev(ev_ss));
  btn_edge u_lr (.clk(clk), .rst(rst), .btn(btn_lr), .ev(ev_lr));

`ifdef LAP_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_load;
`else
  logic unused_tick;
  assign unused_tick = tick_10hz;
`endif

  // ev_ss is tested first everywhere, so a simultaneous ev_lr is dropped
  always_comb begin
    state_nxt = state;
    lap_req   = 1'b0;
    clr_req   = 1'b0;
`ifdef LAP_HOLD_EN
    hold_load = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (ev_ss) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (ev_ss || time_max) begin
          state_nxt = ST_PAUSE;
        end else if (ev_lr) begin
          lap_req = 1'b1;
`ifdef LAP_HOLD_EN
          state_nxt = ST_HOLD;
          hold_load = 1'b1;
`endif
        end
      end
      ST_PAUSE: begin
        if (ev_ss) begin
          if (!time_max) state_nxt = ST_RUN;
        end else if (ev_lr) begin
          clr_req   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
`ifdef LAP_HOLD_EN
      ST_HOLD: begin
        if (ev_ss || time_max) begin
          state_nxt = ST_PAUSE;
        end else if (ev_lr) begin
          lap_req   = 1'b1;
          hold_load = 1'b1;
        end else if (tick_10hz && hold_cnt == HOLD_W'(1)) begin
          state_nxt = ST_RUN;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      lap_strobe <= 1'b0;
      count_clr  <= 1'b0;
      lap_clr    <= 1'b0;
      lap_count  <= '0;
    end else begin
      state      <= state_nxt;
      lap_strobe <= lap_req;
      count_clr  <= clr_req;
      lap_clr    <= clr_req;
      if (clr_req) begin
        lap_count <= '0;
      end else if (lap_req && lap_count != '1) begin
        lap_count <= lap_count + LAP_CNT_W'(1);
      end
    end
  end

`ifdef LAP_HOLD_EN
  // the decrement to zero coincides with the HOLD -> RUN transition
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (hold_load) begin
      hold_cnt <= HOLD_W'(HOLD_TICKS);
    end else if (state == ST_HOLD && tick_10hz && hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HOLD_W'(1);
    end
  end

  assign disp_freeze = (state == ST_HOLD);
`else
  assign disp_freeze = 1'b0;
`endif

  assign count_en = (state == ST_RUN) || (state == ST_HOLD);
  assign state_o  = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - randomized self-checking bench for stopwatch_ctrl against a behavioural model
module tb_stopwatch_ctrl;

`ifdef LAP_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_ss = 1'b0, btn_lr = 1'b0, tick_10hz = 1'b0, time_max = 1'b0;
  logic       count_en, count_clr, lap_strobe, lap_clr, disp_freeze;
  logic [3:0] lap_count;
  logic [1:0] state_o;

  int n_vec = 0;
  int n_err = 0;

  // model: 0 idle, 1 run, 2 pause, 3 hold
  int m_st, m_laps, m_left;
  bit m_tmax;

  stopwatch_ctrl #(.HOLD_TICKS(20), .LAP_CNT_W(4)) dut (
    .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .tick_10hz(tick_10hz), .time_max(time_max),
    .count_en(count_en), .count_clr(count_clr), .lap_strobe(lap_strobe),
    .lap_clr(lap_clr), .disp_freeze(disp_freeze), .lap_count(lap_count),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] exp_vec();
    return {2'(m_st), (m_st == 1 || m_st == 3), (m_st == 3), 4'(m_laps)};
  endfunction

  function automatic logic [7:0] obs_vec();
    return {state_o, count_en, disp_freeze, lap_count};
  endfunction

  function automatic void model_reset();
    m_st = 0; m_laps = 0; m_left = 0;
  endfunction

  function automatic void model_ev(input bit ss, input bit lr, output bit e_lap, output bit e_clr);
    e_lap = 1'b0;
    e_clr = 1'b0;
    if (ss) begin
      if (m_st == 0) m_st = 1;
      else if (m_st == 1 || m_st == 3) m_st = 2;
      else if (m_st == 2 && !m_tmax) m_st = 1;
    end else if (lr) begin
      if (m_st == 1 || m_st == 3) begin
        e_lap = 1'b1;
        if (m_laps < 15) m_laps++;
        if (HOLD_EN) begin
          m_st = 3;
          m_left = 20;
        end
      end else if (m_st == 2) begin
        e_clr = 1'b1;
        m_laps = 0;
        m_st = 0;
      end
    end
  endfunction

  function automatic void model_tick();
    if (m_st == 3) begin
      m_left--;
      if (m_left == 0) m_st = 1;
    end
  endfunction

  // raise levels, sample strobes 4 clk later (event + 1), then sample again one clk on
  task automatic press(input bit ss, input bit lr, output logic [2:0] strb, output logic late);
    @(negedge clk);
    btn_ss = ss;
    btn_lr = lr;
    repeat (4) @(posedge clk);
    @(negedge clk);
    strb = {lap_strobe, count_clr, lap_clr};
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    @(negedge clk);
    late = lap_strobe | count_clr | lap_clr;
    repeat (3) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk);
    tick_10hz = 1'b1;
    @(negedge clk);
    tick_10hz = 1'b0;
    model_tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    time_max = 1'b0;
    m_tmax = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_press(input bit ss, input bit lr, input string nm);
    logic [2:0] strb;
    logic late;
    bit e_lap, e_clr;
    press(ss, lr, strb, late);
    model_ev(ss, lr, e_lap, e_clr);
    n_vec++;
    if (strb !== {e_lap, e_clr, e_clr} || late !== 1'b0) begin
      n_err++;
      $display("FAIL %s_strobe: got lap/cclr/lclr=%b late=%b want %b late=0", nm, strb, late, {e_lap, e_clr, e_clr});
    end
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL %s_state: got st/en/frz/laps=%b want %b", nm, obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset();
    logic [2:0] strb;
    logic late;
    repeat (2) @(negedge clk);
    model_reset();
    n_vec++;
    if ({obs_vec(), lap_strobe, count_clr, lap_clr} !== 11'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want all zero", {obs_vec(), lap_strobe, count_clr, lap_clr});
    end
    rst = 1'b0;
    m_tmax = 1'b0;
    press(1'b0, 1'b1, strb, late);
    n_vec++;
    if ({obs_vec(), strb} !== 11'b0) begin
      n_err++;
      $display("FAIL idle_lr_ignored: got %b want all zero", {obs_vec(), strb});
    end
  endtask

  task automatic test_start();
    @(negedge clk);
    btn_ss = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (state_o !== 2'd0 || count_en !== 1'b0) begin
      n_err++;
      $display("FAIL start_latency_early: got state=%0d en=%b want state=0 en=0", state_o, count_en);
    end
    @(negedge clk);
    n_vec++;
    if (state_o !== 2'd1 || count_en !== 1'b1) begin
      n_err++;
      $display("FAIL start_latency: got state=%0d en=%b want state=1 en=1", state_o, count_en);
    end
    btn_ss = 1'b0;
    repeat (3) @(negedge clk);
    m_st = 1;
  endtask

  task automatic run_hold_out(input string nm);
    repeat (19) tick();
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL %s_19ticks: got %b want %b", nm, obs_vec(), exp_vec());
    end
    tick();
    n_vec++;
    if (obs_vec() !== exp_vec() || state_o !== 2'd1) begin
      n_err++;
      $display("FAIL %s_20ticks: got %b want %b (state run)", nm, obs_vec(), exp_vec());
    end
  endtask

  task automatic test_lap();
    int n;
    do_reset();
    do_press(1'b1, 1'b0, "lap_start");
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      do_press(1'b0, 1'b1, "lap");
      run_hold_out("lap_hold");
    end
  endtask

  task automatic test_hold_reload();
    int k;
    do_reset();
    do_press(1'b1, 1'b0, "reload_start");
    do_press(1'b0, 1'b1, "reload_lap1");
    k = $urandom_range(1, 19);
    repeat (k) tick();
    do_press(1'b0, 1'b1, "reload_lap2");
    run_hold_out("reload_hold");
  endtask

  task automatic test_pause_clear();
    do_reset();
    do_press(1'b1, 1'b0, "clr_start");
    repeat ($urandom_range(1, 3)) do_press(1'b0, 1'b1, "clr_lap");
    do_press(1'b1, 1'b0, "clr_pause");
    do_press(1'b0, 1'b1, "clr_clear");
  endtask

  task automatic test_simultaneous();
    do_reset();
    do_press(1'b1, 1'b0, "both_start");
    do_press(1'b1, 1'b1, "both_run");
  endtask

  task automatic test_time_max();
    do_reset();
    do_press(1'b1, 1'b0, "tmax_start");
    @(negedge clk);
    time_max = 1'b1;
    m_tmax = 1'b1;
    m_st = 2;
    @(negedge clk);
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL tmax_pause: got %b want %b", obs_vec(), exp_vec());
    end
    do_press(1'b1, 1'b0, "tmax_ss_ignored");
    time_max = 1'b0;
    m_tmax = 1'b0;
    do_press(1'b1, 1'b0, "tmax_resume");
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    do_press(1'b1, 1'b0, "rsthold_start");
    do_press(1'b0, 1'b1, "rsthold_lap");
    repeat ($urandom_range(1, 5)) tick();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({obs_vec(), lap_strobe, count_clr, lap_clr} !== 11'b0) begin
      n_err++;
      $display("FAIL rst_in_hold: got %b want all zero", {obs_vec(), lap_strobe, count_clr, lap_clr});
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_saturation();
    do_reset();
    do_press(1'b1, 1'b0, "sat_start");
    for (int i = 0; i < 17; i++) do_press(1'b0, 1'b1, "sat_lap");
    n_vec++;
    if (lap_count !== 4'd15) begin
      n_err++;
      $display("FAIL sat_final: got lap_count=%0d want 15", lap_count);
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        do_press(1'b1, 1'b0, "rnd_ss");
      end else if (r <= 6) begin
        do_press(1'b0, 1'b1, "rnd_lr");
      end else begin
        repeat ($urandom_range(1, 25)) tick();
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
          n_err++;
          $display("FAIL rnd_ticks: got %b want %b", obs_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_lap();
    test_hold_reload();
    test_pause_clear();
    test_simultaneous();
    test_time_max();
    test_reset_in_hold();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
